// File: rtl/mips_mc_control_if.sv
// rtl/mips_mc_control_if.sv - control-unit to datapath/memory signal bundle
interface mips_mc_control_if #(
    parameter int CNT_WIDTH = 32
);
    logic [5:0]           Op;
    logic [5:0]           Funct;
    logic                 Zero;
    logic                 mem_ready;
    logic                 mem_req;
    logic                 IorD;
    logic                 MemWrite;
    logic                 IRWrite;
    logic                 PCWrite;
    logic                 Branch;
    logic                 PCEn;
    logic [1:0]           PCSrc;
    logic                 ALUSrcA;
    logic [2:0]           ALUSrcB;
    logic [2:0]           ALUControl;
    logic                 RegWrite;
    logic                 RegDst;
    logic                 MemtoReg;
    logic                 fault;
    logic [1:0]           fault_code;
    logic [CNT_WIDTH-1:0] instr_count;

    modport master (
        input  Op, Funct, Zero, mem_ready,
        output mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch, PCEn, PCSrc,
               ALUSrcA, ALUSrcB, ALUControl, RegWrite, RegDst, MemtoReg,
               fault, fault_code, instr_count
    );

    modport slave (
        output Op, Funct, Zero, mem_ready,
        input  mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch, PCEn, PCSrc,
               ALUSrcA, ALUSrcB, ALUControl, RegWrite, RegDst, MemtoReg,
               fault, fault_code, instr_count
    );
endinterface

// File: rtl/mips_mc_control.sv
// rtl/mips_mc_control.sv - multicycle MIPS control FSM with memory handshake and watchdog
module mips_mc_control #(
    parameter int WATCHDOG_CYCLES = 16,
    parameter int CNT_WIDTH       = 32,
    parameter bit ENABLE_EXT      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    mips_mc_control_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_BRANCH, S_ADDIEX, S_LOGIEX, S_IMMWB, S_JUMP, S_FAULT
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam int          WD_W     = (WATCHDOG_CYCLES < 2) ? 1 : $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [31:0] WD_LIMIT = WATCHDOG_CYCLES;

    state_t               state, state_nx;
    logic [1:0]           code_q, code_nx;
    logic [WD_W-1:0]      wd_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 waiting, timeout, taken;

    // The watchdog only runs while a memory-access state is stalled; any other cycle clears it.
    assign waiting = ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR)) && !bus.mem_ready;
    assign timeout = (WATCHDOG_CYCLES != 0) && waiting && ((32'(wd_q) + 32'd1) >= WD_LIMIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_FETCH;
            code_q <= 2'b00;
            wd_q   <= '0;
            cnt_q  <= '0;
        end else begin
            state  <= state_nx;
            code_q <= code_nx;
            wd_q   <= (waiting && !timeout) ? wd_q + 1'b1 : '0;
            if (state == S_FETCH && bus.mem_ready)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        bus.mem_req    = 1'b0;
        bus.IorD       = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.PCWrite    = 1'b0;
        bus.Branch     = 1'b0;
        bus.PCSrc      = 2'b00;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 3'b000;
        bus.ALUControl = 3'b000;
        bus.RegWrite   = 1'b0;
        bus.RegDst     = 1'b0;
        bus.MemtoReg   = 1'b0;
        taken          = 1'b0;
        state_nx       = state;
        code_nx        = code_q;

        case (state)
            S_FETCH: begin
                bus.mem_req    = reset;
                bus.ALUSrcB    = 3'b001;
                bus.ALUControl = ALU_ADD;
                bus.IRWrite    = bus.mem_ready;
                bus.PCWrite    = bus.mem_ready;
                if (bus.mem_ready)  state_nx = S_DECODE;
                else if (timeout)   state_nx = S_FAULT;
            end
            S_DECODE: begin
                bus.ALUSrcB    = 3'b011;
                bus.ALUControl = ALU_ADD;
                case (bus.Op)
                    OP_LW, OP_SW:    state_nx = S_MEMADR;
                    OP_R:            state_nx = S_EXEC;
                    OP_BEQ:          state_nx = S_BRANCH;
                    OP_BNE:          state_nx = ENABLE_EXT ? S_BRANCH : S_FAULT;
                    OP_ADDI:         state_nx = ENABLE_EXT ? S_ADDIEX : S_FAULT;
                    OP_ANDI, OP_ORI: state_nx = ENABLE_EXT ? S_LOGIEX : S_FAULT;
                    OP_J:            state_nx = ENABLE_EXT ? S_JUMP : S_FAULT;
                    default:         state_nx = S_FAULT;
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUSrcB    = 3'b010;
                bus.ALUControl = ALU_ADD;
                state_nx       = (bus.Op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.mem_req = 1'b1;
                bus.IorD    = 1'b1;
                if (bus.mem_ready)  state_nx = S_MEMWB;
                else if (timeout)   state_nx = S_FAULT;
            end
            S_MEMWB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
                state_nx     = S_FETCH;
            end
            S_MEMWR: begin
                bus.mem_req  = 1'b1;
                bus.IorD     = 1'b1;
                bus.MemWrite = 1'b1;
                if (bus.mem_ready)  state_nx = S_FETCH;
                else if (timeout)   state_nx = S_FAULT;
            end
            S_EXEC: begin
                bus.ALUSrcA = 1'b1;
                state_nx    = S_ALUWB;
                case (bus.Funct)
                    6'b100000: bus.ALUControl = ALU_ADD;
                    6'b100010: bus.ALUControl = ALU_SUB;
                    6'b100100: bus.ALUControl = ALU_AND;
                    6'b100101: bus.ALUControl = ALU_OR;
                    6'b101010: bus.ALUControl = ALU_SLT;
                    default:   state_nx       = S_FAULT;
                endcase
            end
            S_ALUWB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
                state_nx     = S_FETCH;
            end
            S_BRANCH: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUControl = ALU_SUB;
                bus.PCSrc      = 2'b01;
                bus.Branch     = 1'b1;
                // Op[0] separates bne from beq, so it inverts the sense of Zero.
                taken          = bus.Zero ^ bus.Op[0];
                state_nx       = S_FETCH;
            end
            S_ADDIEX: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUSrcB    = 3'b010;
                bus.ALUControl = ALU_ADD;
                state_nx       = S_IMMWB;
            end
            S_LOGIEX: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUSrcB    = 3'b100;
                bus.ALUControl = bus.Op[0] ? ALU_OR : ALU_AND;
                state_nx       = S_IMMWB;
            end
            S_IMMWB: begin
                bus.RegWrite = 1'b1;
                state_nx     = S_FETCH;
            end
            S_JUMP: begin
                bus.PCSrc   = 2'b10;
                bus.PCWrite = 1'b1;
                state_nx    = S_FETCH;
            end
            default: ;
        endcase

        // Timeouts only arise in stalled memory states; decode/exec faults are always illegal encodings.
        if (state_nx == S_FAULT && state != S_FAULT)
            code_nx = timeout ? 2'b10 : 2'b01;
        bus.PCEn = bus.PCWrite | taken;
    end

    assign bus.fault       = (state == S_FAULT);
    assign bus.fault_code  = code_q;
    assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_mips_mc_control.sv
// tb/tb_mips_mc_control.sv - randomized instruction-stream bench for mips_mc_control
module tb_mips_mc_control;
    localparam int PH_F = 0, PH_D = 1, PH_MA = 2, PH_MR = 3, PH_MWB = 4, PH_MWR = 5, PH_EX = 6,
                   PH_AWB = 7, PH_BR = 8, PH_AD = 9, PH_LG = 10, PH_IWB = 11, PH_J = 12, PH_FLT = 13;
    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100,
                           BNE = 6'b000101, ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101,
                           JMP = 6'b000010;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op_d = '0, funct_d = '0;
    logic       zero_d = 1'b0, mr_d = 1'b0;

    int n_cmp = 0, n_bad = 0;
    int sel = 0, W = 16, EXT = 1;
    logic [31:0] cmask = 32'hFFFF_FFFF, cnt_exp = '0;
    logic [1:0]  fc_exp = 2'b00;
    int abort_at = -1;
    int fq[$];
    int phs[$];

    always #5 clk = ~clk;

    mips_mc_control_if #(.CNT_WIDTH(32)) ia ();
    mips_mc_control_if #(.CNT_WIDTH(3))  ib ();

    assign ia.Op = op_d;  assign ia.Funct = funct_d;  assign ia.Zero = zero_d;  assign ia.mem_ready = mr_d;
    assign ib.Op = op_d;  assign ib.Funct = funct_d;  assign ib.Zero = zero_d;  assign ib.mem_ready = mr_d;

    mips_mc_control #(.WATCHDOG_CYCLES(16), .CNT_WIDTH(32), .ENABLE_EXT(1'b1))
        dut_a (.clk(clk), .reset(reset), .bus(ia));
    mips_mc_control #(.WATCHDOG_CYCLES(4), .CNT_WIDTH(3), .ENABLE_EXT(1'b0))
        dut_b (.clk(clk), .reset(reset), .bus(ib));

    wire [21:0] vec_a = {ia.mem_req, ia.IorD, ia.MemWrite, ia.IRWrite, ia.PCWrite, ia.Branch, ia.PCEn,
                         ia.PCSrc, ia.ALUSrcA, ia.ALUSrcB, ia.ALUControl, ia.RegWrite, ia.RegDst,
                         ia.MemtoReg, ia.fault, ia.fault_code};
    wire [21:0] vec_b = {ib.mem_req, ib.IorD, ib.MemWrite, ib.IRWrite, ib.PCWrite, ib.Branch, ib.PCEn,
                         ib.PCSrc, ib.ALUSrcA, ib.ALUSrcB, ib.ALUControl, ib.RegWrite, ib.RegDst,
                         ib.MemtoReg, ib.fault, ib.fault_code};
    wire [21:0] obs_vec = (sel != 0) ? vec_b : vec_a;
    wire [31:0] obs_cnt = (sel != 0) ? {29'd0, ib.instr_count} : ia.instr_count;
    wire        obs_req = (sel != 0) ? ib.mem_req : ia.mem_req;
    wire        obs_flt = (sel != 0) ? ib.fault : ia.fault;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {valid, ALUControl} for an R-type funct field
    function automatic logic [3:0] funct_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 4'b1010;
            6'b100010: return 4'b1110;
            6'b100100: return 4'b1000;
            6'b100101: return 4'b1001;
            6'b101010: return 4'b1111;
            default:   return 4'b0000;
        endcase
    endfunction

    function automatic logic [21:0] exp_out(input int ph, input logic [5:0] op, input logic [5:0] fn,
                                            input logic z, input logic mr, input logic [1:0] fc);
        logic req = 0, iord = 0, mw = 0, irw = 0, pcw = 0, br = 0, pcen = 0, srca = 0;
        logic rw = 0, rd = 0, mtr = 0, flt = 0;
        logic [1:0] pcsrc = 0, code = 0;
        logic [2:0] srcb = 0, ctl = 0;
        case (ph)
            PH_F:   begin req = 1; srcb = 3'd1; ctl = 3'b010; irw = mr; pcw = mr; pcen = mr; end
            PH_D:   begin srcb = 3'd3; ctl = 3'b010; end
            PH_MA:  begin srca = 1; srcb = 3'd2; ctl = 3'b010; end
            PH_MR:  begin req = 1; iord = 1; end
            PH_MWB: begin rw = 1; mtr = 1; end
            PH_MWR: begin req = 1; iord = 1; mw = 1; end
            PH_EX:  begin srca = 1; ctl = funct_alu(fn) & 4'h7; end
            PH_AWB: begin rw = 1; rd = 1; end
            PH_BR:  begin srca = 1; ctl = 3'b110; pcsrc = 2'b01; br = 1; pcen = (op == BEQ) ? z : !z; end
            PH_AD:  begin srca = 1; srcb = 3'd2; ctl = 3'b010; end
            PH_LG:  begin srca = 1; srcb = 3'd4; ctl = (op == ANDI) ? 3'b000 : 3'b001; end
            PH_IWB: begin rw = 1; end
            PH_J:   begin pcsrc = 2'b10; pcw = 1; pcen = 1; end
            default: begin flt = 1; code = fc; end
        endcase
        return {req, iord, mw, irw, pcw, br, pcen, pcsrc, srca, srcb, ctl, rw, rd, mtr, flt, code};
    endfunction

    task automatic plan(input logic [5:0] op, input logic [5:0] fn);
        phs = {PH_F, PH_D};
        case (op)
            LW:        begin phs.push_back(PH_MA); phs.push_back(PH_MR); phs.push_back(PH_MWB); end
            SW:        begin phs.push_back(PH_MA); phs.push_back(PH_MWR); end
            RT:        begin phs.push_back(PH_EX); phs.push_back(funct_alu(fn)[3] ? PH_AWB : PH_FLT); end
            BEQ:       phs.push_back(PH_BR);
            BNE:       phs.push_back(EXT != 0 ? PH_BR : PH_FLT);
            ADDI:      if (EXT != 0) begin phs.push_back(PH_AD); phs.push_back(PH_IWB); end
                       else phs.push_back(PH_FLT);
            ANDI, ORI: if (EXT != 0) begin phs.push_back(PH_LG); phs.push_back(PH_IWB); end
                       else phs.push_back(PH_FLT);
            JMP:       phs.push_back(EXT != 0 ? PH_J : PH_FLT);
            default:   phs.push_back(PH_FLT);
        endcase
    endtask

    function automatic int pick_stall();
        int r;
        if (fq.size() > 0) return fq.pop_front();
        r = $urandom_range(0, 19);
        if (r < 14) return 0;
        if (r < 17) return $urandom_range(1, 3);
        if (r == 17) return W - 1;
        if (r == 18) return W;
        return 40;
    endfunction

    // Called at a falling edge; leaves off at the next falling edge.
    task automatic cycle(input int ph, input logic mr);
        mr_d = mr;
        #1;
        check($sformatf("out ph%0d op%b fn%b", ph, op_d, funct_d), 64'(obs_vec),
              64'(exp_out(ph, op_d, funct_d, zero_d, mr, fc_exp)));
        check("instr_count", 64'(obs_cnt), 64'(cnt_exp));
        if (ph == PH_F && mr) cnt_exp = (cnt_exp + 1) & cmask;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        mr_d  = 1'($urandom);
        #1;
        check("rst mem_req", 64'(obs_req), 64'd0);
        check("rst instr_count", 64'(obs_cnt), 64'd0);
        check("rst fault", 64'(obs_flt), 64'd0);
        @(negedge clk);
        reset   = 1'b1;
        cnt_exp = '0;
        fc_exp  = 2'b00;
    endtask

    task automatic tick(input int ph, input logic mr, inout int n, output bit ab);
        ab = (n == abort_at);
        if (ab) begin
            do_reset();
            return;
        end
        n++;
        cycle(ph, mr);
    endtask

    task automatic fault_tail(inout int n);
        bit ab;
        repeat (3) begin
            tick(PH_FLT, 1'($urandom), n, ab);
            if (ab) return;
        end
        do_reset();
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        int n = 0, stall, waits;
        bit ab;
        op_d = op; funct_d = fn; zero_d = z;
        plan(op, fn);
        foreach (phs[i]) begin
            if (phs[i] == PH_FLT) begin
                fc_exp = 2'b01;
                fault_tail(n);
                return;
            end
            if (phs[i] == PH_F || phs[i] == PH_MR || phs[i] == PH_MWR) begin
                stall = pick_stall();
                waits = 0;
                forever begin
                    tick(phs[i], waits == stall, n, ab);
                    if (ab) return;
                    if (waits == stall) break;
                    waits++;
                    if (W != 0 && waits >= W) begin
                        fc_exp = 2'b10;
                        fault_tail(n);
                        return;
                    end
                end
            end else begin
                tick(phs[i], 1'($urandom), n, ab);
                if (ab) return;
            end
        end
    endtask

    task automatic run_random(input int count);
        logic [5:0] ops [9] = '{LW, SW, RT, BEQ, BNE, ADDI, ANDI, ORI, JMP};
        logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [5:0] op, fn;
        for (int k = 0; k < count; k++) begin
            int r = $urandom_range(0, 9);
            op = (r == 9) ? 6'($urandom) : ops[r];
            fn = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            abort_at = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 6) : -1;
            run_instr(op, fn, 1'($urandom));
        end
        abort_at = -1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b1;

        abort_at = 3; fq = {0};
        run_instr(LW, 6'd0, 1'b0);
        abort_at = -1;
        fq = {0, 0};  run_instr(LW, 6'd0, 1'b0);
        fq = {0, 3};  run_instr(SW, 6'd0, 1'b0);
        fq = {0};     run_instr(BEQ, 6'd0, 1'b1);
        fq = {0};     run_instr(BNE, 6'd0, 1'b1);
        fq = {0};     run_instr(JMP, 6'd0, 1'b0);
        fq = {0};     run_instr(ANDI, 6'd0, 1'b0);
        fq = {0};     run_instr(RT, 6'b111111, 1'b0);
        fq = {0, 15}; run_instr(SW, 6'd0, 1'b0);
        fq = {16};    run_instr(LW, 6'd0, 1'b0);
        run_random(300);

        sel = 1; W = 4; EXT = 0; cmask = 32'h7;
        do_reset();
        fq = {0};  run_instr(ANDI, 6'd0, 1'b0);
        fq = {40}; run_instr(LW, 6'd0, 1'b0);
        fq = {0, 3}; run_instr(LW, 6'd0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            fq = {0}; run_instr(BEQ, 6'd0, 1'($urandom));
        end
        run_random(150);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
Next-generation multicycle MIPS control unit that sequences fetch/decode/execute for the shared instruction/data memory datapath. It extends the original Moore FSM with bne, addi, andi, ori and j. It adds a memory request/ready handshake with wait states, a watchdog, a sticky fault state and a retired-instruction counter. It drives every datapath select and enable, including a ready-to-use PCEn.

Parameters:
WATCHDOG_CYCLES, 16, max wait cycles per memory access before fault; 0 disables the watchdog.
CNT_WIDTH, 32, width of instr_count.
ENABLE_EXT, 1, 1 decodes bne/addi/andi/ori/j; 0 treats those opcodes as illegal.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
Op  in  6  Instr[31:26].
Funct  in  6  Instr[5:0].
Zero  in  1  ALU zero flag for the current ALUResult.
mem_ready  in  1  memory completes the current access this cycle.
mem_req  out  1  memory access requested.
IorD  out  1  0 selects PC address, 1 selects ALUOut address.
MemWrite  out  1  memory write enable.
IRWrite  out  1  instruction register load.
PCWrite  out  1  unconditional PC write.
Branch  out  1  branch state active.
PCEn  out  1  PC load, qualified by Zero.
PCSrc  out  2  00 ALUResult, 01 ALUOut, 10 jump target.
ALUSrcA  out  1  0 PC, 1 A.
ALUSrcB  out  3  000 B, 001 const 4, 010 SignImm, 011 SignImm<<2, 100 ZeroImm.
ALUControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
RegWrite  out  1  register file write.
RegDst  out  1  0 rt, 1 rd.
MemtoReg  out  1  0 ALUOut, 1 Data.
fault  out  1  sticky fault flag.
fault_code  out  2  00 none, 01 illegal opcode/funct, 10 memory timeout.
instr_count  out  CNT_WIDTH  count of completed fetches.

Behaviour:
- Moore FSM; all outputs decode from the registered state, except PCEn, IRWrite/PCWrite in FETCH, and fault-driven transitions.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, LOGIEX, IMMWB, JUMP, FAULT.
- Reset (reset=0, async) forces the following, held while reset=0:
  - state=FETCH, fault=0, fault_code=00, instr_count=0, watchdog=0.
  - Only the FETCH combinational outputs are active, and mem_req is forced 0.
- FETCH:
  - Drives mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=001, ALUControl=010, PCSrc=00.
  - IRWrite=PCWrite=mem_ready.
  - On mem_ready go to DECODE and increment instr_count (wraps modulo 2^CNT_WIDTH).
- DECODE: ALUSrcA=0, ALUSrcB=011, ALUControl=010. Next state by Op:
  - lw 100011 / sw 101011 go to MEMADR.
  - R 000000 goes to EXEC.
  - beq 000100 / bne 000101 go to BRANCH.
  - addi 001000 goes to ADDIEX.
  - andi 001100 / ori 001101 go to LOGIEX.
  - j 000010 goes to JUMP.
  - Any other Op goes to FAULT with code 01.
- MEMADR: ALUSrcA=1, ALUSrcB=010, add. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, IorD=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1. Goes to FETCH.
- MEMWR: mem_req=1, IorD=1, MemWrite=1. Holds until mem_ready, then goes to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=000. ALUControl from Funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Any other Funct goes to FAULT with code 01; otherwise go to ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=000, sub, PCSrc=01, Branch=1.
  - PCEn = Zero for beq, ~Zero for bne.
  - Goes to FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=010, add. Goes to IMMWB.
- LOGIEX: ALUSrcA=1, ALUSrcB=100, and for andi / or for ori. Goes to IMMWB.
- IMMWB: RegWrite=1, RegDst=0, MemtoReg=0. Goes to FETCH.
- JUMP: PCSrc=10, PCWrite=1. Goes to FETCH.
- PCEn = PCWrite | branch-taken term; 0 in every other state.
- Watchdog (when WATCHDOG_CYCLES≠0):
  - Clears on entry to FETCH/MEMRD/MEMWR.
  - Increments each cycle the FSM waits with mem_ready=0.
  - When it reaches WATCHDOG_CYCLES with mem_ready still 0, the next state is FAULT with code 10.
  - mem_ready in the same cycle wins over timeout.
- FAULT:
  - All enables and mem_req are 0; fault=1 and fault_code are held.
  - Exit only by reset.
  - instr_count frozen.
- Default values in every state for outputs not listed above: all enables 0, selects 0.

Test Plan:
- Reset low mid-MEMRD, then release → next cycle state FETCH, mem_req=1, instr_count=0, fault=0.
- lw (Op=100011), mem_ready always 1 → exactly 5 cycles FETCH…MEMWB, RegWrite=1 with MemtoReg=1 in cycle 5, instr_count=1.
- sw with mem_ready held 0 for 3 cycles in MEMWR → MemWrite=1 and mem_req=1 for 4 cycles, then FETCH; WATCHDOG_CYCLES=16 causes no fault.
- beq with Zero=1 and bne with Zero=1 → PCEn=1 and PCEn=0 respectively in BRANCH, PCSrc=01; j → PCEn=1, PCSrc=10.
- andi (Op=001100) → ALUSrcB=100, ALUControl=000, then IMMWB RegWrite=1, RegDst=0; with ENABLE_EXT=0 the same Op gives fault=1, fault_code=01.
- WATCHDOG_CYCLES=4, mem_ready stuck 0 in FETCH → fault=1, fault_code=10 after 4 wait cycles; outputs stay idle until reset.
